factor_judge: RTL and testbench
===============================

// Module: factor_judge
// PURPOSE
//  Game-logic stage fed by the 0-9 number latch. START_1P loads the latched NUM as the
//  target. The player then presses one-pulse prime buttons (2/3/5/7) to divide the
//  target down to 1 before a countdown expires. The block reports the current value,
//  time left, step count and a result code to the display stage.
// PARAMETERS
//  TICK_CYCLES  50_000_000  CLK cycles per countdown second (benches use 4)
//  TIME_LIMIT   9           countdown start value in seconds, 1..15
// PORTS
//  CLK       in   1  system clock
//  RST       in   1  synchronous reset, active-high
//  START_1P  in   1  one-cycle pulse: load NUM and start a round
//  NUM       in   4  target value, sampled only on START_1P
//  P2_1P     in   1  one-cycle pulse: divide by 2
//  P3_1P     in   1  one-cycle pulse: divide by 3
//  P5_1P     in   1  one-cycle pulse: divide by 5
//  P7_1P     in   1  one-cycle pulse: divide by 7
//  CUR       out  4  current remaining value
//  TIME      out  4  seconds left
//  STEPS     out  3  correct divisions this round, saturating at 7
//  BUSY      out  1  high while state is PLAY
//  RESULT    out  2  00 none, 01 clear, 10 miss, 11 timeout
// BEHAVIOUR
//  - All outputs and state are registered. Reset gives: state IDLE, CUR=0,
//    TIME=TIME_LIMIT, STEPS=0, BUSY=0, RESULT=00, tick counter=0.
//  - States: IDLE, PLAY, CLEAR, MISS, TOUT. BUSY=(state==PLAY).
//    RESULT is 00 in IDLE/PLAY, 01 in CLEAR, 10 in MISS, 11 in TOUT.
//  - START_1P in any state, including PLAY (restart):
//      CUR<=NUM, TIME<=TIME_LIMIT, STEPS<=0, tick counter<=0.
//      Next state is PLAY, or CLEAR directly if NUM<2.
//    START_1P has priority over button presses and ticks in the same cycle.
//  - PLAY, number of button pulses high in the cycle:
//      zero  -> no change
//      two or more -> MISS; CUR unchanged
//      exactly one, divisor p -> CUR%p==0: CUR<=CUR/p, STEPS<=STEPS+1 (saturating),
//        and next state CLEAR if CUR/p==1, else PLAY.
//        CUR%p!=0: MISS, CUR unchanged.
//    Outputs update on the edge after the pulse (1-cycle latency).
//  - Arithmetic: CUR is 4-bit unsigned. Division is exact, with no remainder kept.
//    Any value 0..15 is legal. 11 and 13 can only end in MISS or TOUT.
//  - Tick: a counter runs only in PLAY and counts 0..TICK_CYCLES-1, then wraps. Each wrap
//    is one tick. The first tick comes exactly TICK_CYCLES cycles after the START edge.
//    Each tick does TIME<=TIME-1. A tick with TIME==1 gives TIME<=0 and state TOUT.
//  - Tick and a button in the same cycle: the button is evaluated first. If the button
//    ends the round (CLEAR/MISS), the tick is ignored. Otherwise the tick applies too.
//  - CLEAR/MISS/TOUT hold CUR, TIME and STEPS frozen and ignore buttons until START_1P.
//    The tick counter is held at 0 outside PLAY.
//  - RST mid-round wins over every input and returns to the reset values on that edge.
// TESTING (TICK_CYCLES=4, TIME_LIMIT=3)
//  1. START with NUM=8, then P2, P2, P2 one cycle apart -> CUR 4,2,1; STEPS=3;
//     RESULT=01; BUSY=0.
//  2. START with NUM=9, then P2 -> RESULT=10, CUR=9, STEPS=0.
//     A later P3 leaves everything frozen.
//  3. START with NUM=6, no presses -> TIME 3,2,1,0 at cycles 4,8,12 after START;
//     RESULT=11 at cycle 12.
//  4. START with NUM=6, P2 and P3 in the same cycle -> MISS, CUR=6.
//     START with NUM=1 -> CLEAR immediately, STEPS=0.
//  5. START with NUM=6. At cycle 12 (final tick) P2 is high -> CUR=3, TIME=0,
//     state TOUT with RESULT=11.
//     Separately, at cycle 12 P3 followed earlier by P2 -> CLEAR beats the tick.
//  6. Mid-PLAY START with NUM=4 -> restart with CUR=4, TIME=3, STEPS=0.
//     Mid-PLAY RST -> CUR=0, TIME=3, RESULT=00, BUSY=0.

Source files
------------

// File: rtl/factor_judge.sv
// factor_judge: game-logic stage. A round loads a target value, and the player divides it
// down to 1 with the prime buttons (2/3/5/7) before the countdown runs out.
module factor_judge #(
   parameter int unsigned TICK_CYCLES = 50_000_000,
   parameter int unsigned TIME_LIMIT  = 9
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_1p_i,
   input  logic [3:0] num_i,
   input  logic       p2_1p_i,
   input  logic       p3_1p_i,
   input  logic       p5_1p_i,
   input  logic       p7_1p_i,
   output logic [3:0] cur_o,
   output logic [3:0] time_o,
   output logic [2:0] steps_o,
   output logic       busy_o,
   output logic [1:0] result_o
);

   localparam int unsigned CntW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TICK_CYCLES - 1);
   localparam logic [3:0] TimeInit = 4'(TIME_LIMIT);

   typedef enum logic [2:0] {StIdle, StPlay, StClear, StMiss, StTout} state_e;

   state_e          state_q;
   logic [3:0]      cur_q;
   logic [3:0]      time_q;
   logic [2:0]      steps_q;
   logic            busy_q;
   logic [1:0]      result_q;
   logic [CntW-1:0] cnt_q;

   logic [2:0] n_press;
   logic [3:0] quot;
   logic       divisible;
   logic       tick;
   logic [2:0] steps_inc;

   // Decode the single pressed button into quotient and divisibility of the current value.
   always_comb begin
      n_press   = 3'(p2_1p_i) + 3'(p3_1p_i) + 3'(p5_1p_i) + 3'(p7_1p_i);
      quot      = cur_q;
      divisible = 1'b0;
      unique case ({p7_1p_i, p5_1p_i, p3_1p_i, p2_1p_i})
         4'b0001: begin quot = cur_q / 4'd2; divisible = (cur_q % 4'd2) == 4'd0; end
         4'b0010: begin quot = cur_q / 4'd3; divisible = (cur_q % 4'd3) == 4'd0; end
         4'b0100: begin quot = cur_q / 4'd5; divisible = (cur_q % 4'd5) == 4'd0; end
         4'b1000: begin quot = cur_q / 4'd7; divisible = (cur_q % 4'd7) == 4'd0; end
         default: begin quot = cur_q; divisible = 1'b0; end
      endcase
      tick      = (cnt_q == CntLast);
      steps_inc = (steps_q == 3'd7) ? 3'd7 : steps_q + 3'd1;
   end

   // Round FSM with registered outputs; start beats buttons, buttons are resolved before ticks.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         cur_q    <= 4'd0;
         time_q   <= TimeInit;
         steps_q  <= 3'd0;
         busy_q   <= 1'b0;
         result_q <= 2'b00;
         cnt_q    <= '0;
      end else if (start_1p_i) begin
         cur_q   <= num_i;
         time_q  <= TimeInit;
         steps_q <= 3'd0;
         cnt_q   <= '0;
         if (num_i < 4'd2) begin
            state_q  <= StClear;
            busy_q   <= 1'b0;
            result_q <= 2'b01;
         end else begin
            state_q  <= StPlay;
            busy_q   <= 1'b1;
            result_q <= 2'b00;
         end
      end else if (state_q == StPlay) begin
         if (n_press >= 3'd2 || (n_press == 3'd1 && !divisible)) begin
            state_q  <= StMiss;
            busy_q   <= 1'b0;
            result_q <= 2'b10;
            cnt_q    <= '0;
         end else if (n_press == 3'd1 && quot == 4'd1) begin
            cur_q    <= quot;
            steps_q  <= steps_inc;
            state_q  <= StClear;
            busy_q   <= 1'b0;
            result_q <= 2'b01;
            cnt_q    <= '0;
         end else begin
            if (n_press == 3'd1) begin
               cur_q   <= quot;
               steps_q <= steps_inc;
            end
            if (tick) begin
               cnt_q  <= '0;
               time_q <= time_q - 4'd1;
               if (time_q == 4'd1) begin
                  state_q  <= StTout;
                  busy_q   <= 1'b0;
                  result_q <= 2'b11;
               end
            end else begin
               cnt_q <= cnt_q + CntW'(1);
            end
         end
      end else begin
         cnt_q <= '0;
      end
   end

   assign cur_o    = cur_q;
   assign time_o   = time_q;
   assign steps_o  = steps_q;
   assign busy_o   = busy_q;
   assign result_o = result_q;

endmodule

// File: tb/tb_factor_judge.sv
// Bench for factor_judge: directed round scenarios plus random button traffic, all checked
// against an integer round model.
module tb_factor_judge;

   localparam int unsigned TC = 4;
   localparam int unsigned TL = 3;

   logic       clk = 1'b0;
   logic       rst, start, p2, p3, p5, p7;
   logic [3:0] num;
   logic [3:0] cur, tim;
   logic [2:0] steps;
   logic       busy;
   logic [1:0] result;

   int n_cmp = 0;
   int n_err = 0;

   // Model: 0 idle, 1 play, 2 clear, 3 miss, 4 timeout; elapsed = cycles spent in play.
   int m_state, m_cur, m_time, m_steps, m_elapsed;

   factor_judge #(.TICK_CYCLES(TC), .TIME_LIMIT(TL)) dut (
      .clk_i(clk), .rst_i(rst), .start_1p_i(start), .num_i(num),
      .p2_1p_i(p2), .p3_1p_i(p3), .p5_1p_i(p5), .p7_1p_i(p7),
      .cur_o(cur), .time_o(tim), .steps_o(steps), .busy_o(busy), .result_o(result)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step(input logic r, s, input int n, input logic a, b, c, d);
      int np, p;
      bit ended;
      if (r) begin
         m_state = 0; m_cur = 0; m_time = TL; m_steps = 0; m_elapsed = 0;
      end else if (s) begin
         m_cur = n; m_time = TL; m_steps = 0; m_elapsed = 0;
         m_state = (n < 2) ? 2 : 1;
      end else if (m_state == 1) begin
         np = int'(a) + int'(b) + int'(c) + int'(d);
         ended = 0;
         if (np >= 2) begin
            m_state = 3; ended = 1;
         end else if (np == 1) begin
            p = a ? 2 : b ? 3 : c ? 5 : 7;
            if (m_cur % p != 0) begin
               m_state = 3; ended = 1;
            end else begin
               m_cur = m_cur / p;
               m_steps = (m_steps < 7) ? m_steps + 1 : 7;
               if (m_cur == 1) begin m_state = 2; ended = 1; end
            end
         end
         if (!ended) begin
            m_elapsed++;
            if (m_elapsed % TC == 0) begin
               m_time--;
               if (m_time == 0) m_state = 4;
            end
         end
      end
   endtask

   task automatic check_all();
      int exp_res;
      exp_res = (m_state >= 2) ? m_state - 1 : 0;
      check_val("cur", int'(cur), m_cur);
      check_val("time", int'(tim), m_time);
      check_val("steps", int'(steps), m_steps);
      check_val("busy", int'(busy), (m_state == 1) ? 1 : 0);
      check_val("result", int'(result), exp_res);
   endtask

   // One clock: drive inputs, let the edge happen, advance the model, check 1ns later.
   task automatic cyc(input logic r, s, input int n, input logic a, b, c, d);
      rst = r; start = s; num = 4'(n); p2 = a; p3 = b; p5 = c; p7 = d;
      @(posedge clk);
      model_step(r, s, n, a, b, c, d);
      #1;
      check_all();
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst = 1; start = 0; num = 0; p2 = 0; p3 = 0; p5 = 0; p7 = 0;
      cyc(1, 0, 0, 0, 0, 0, 0);
      check_val("rst_time", int'(tim), TL);
      check_val("rst_cur", int'(cur), 0);

      // Scenario 1: 8 -> 4 -> 2 -> 1
      cyc(0, 1, 8, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      check_val("s1_cur", int'(cur), 1);
      check_val("s1_steps", int'(steps), 3);
      check_val("s1_result", int'(result), 1);
      check_val("s1_busy", int'(busy), 0);

      // Scenario 2: 9 / 2 misses, later presses ignored
      cyc(0, 1, 9, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      check_val("s2_result", int'(result), 2);
      check_val("s2_cur", int'(cur), 9);
      cyc(0, 0, 0, 0, 1, 0, 0);
      check_val("s2_frozen", int'(cur), 9);

      // Scenario 3: countdown to timeout
      cyc(0, 1, 6, 0, 0, 0, 0);
      for (int i = 1; i <= 12; i++) begin
         cyc(0, 0, 0, 0, 0, 0, 0);
         if (i == 4) check_val("s3_t4", int'(tim), 2);
         if (i == 8) check_val("s3_t8", int'(tim), 1);
         if (i == 12) begin
            check_val("s3_t12", int'(tim), 0);
            check_val("s3_res", int'(result), 3);
         end
      end

      // Scenario 4: double press, then trivial target
      cyc(0, 1, 6, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 1, 0, 0);
      check_val("s4_miss", int'(result), 2);
      check_val("s4_cur", int'(cur), 6);
      cyc(0, 1, 1, 0, 0, 0, 0);
      check_val("s4_clear", int'(result), 1);

      // Scenario 5a: valid press on the final tick still times out
      cyc(0, 1, 6, 0, 0, 0, 0);
      idle(11);
      cyc(0, 0, 0, 1, 0, 0, 0);
      check_val("s5a_cur", int'(cur), 3);
      check_val("s5a_time", int'(tim), 0);
      check_val("s5a_res", int'(result), 3);
      // Scenario 5b: clearing press on the final tick beats it
      cyc(0, 1, 6, 0, 0, 0, 0);
      idle(10);
      cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0, 0);
      check_val("s5b_res", int'(result), 1);
      check_val("s5b_time", int'(tim), 1);

      // Scenario 6: restart and reset mid-round
      cyc(0, 1, 6, 0, 0, 0, 0);
      idle(5);
      cyc(0, 1, 4, 0, 0, 0, 0);
      check_val("s6_cur", int'(cur), 4);
      check_val("s6_time", int'(tim), 3);
      cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      check_val("s6_rst_cur", int'(cur), 0);
      check_val("s6_rst_busy", int'(busy), 0);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(199) == 0), ($urandom_range(14) == 0), int'($urandom_range(15)),
             ($urandom_range(7) == 0), ($urandom_range(7) == 0),
             ($urandom_range(9) == 0), ($urandom_range(9) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
